// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
//
// Receives PS/2 keyboard frames on the raw kclk/kdata pins. Each validated
// scan-code byte is shifted into a rolling 32-bit keycode history that feeds
// the keyboard decoder. The pins are synchronised, the clock is
// glitch-filtered, and every frame is checked for parity, stop bit and
// inter-edge timeout. Corrupted or partial frames never reach the history.
//
// Parameters:
//   SYNC_STAGES  - synchroniser depth on kclk and kdata (>= 2)
//   FILTER_LEN   - consecutive identical kclk samples needed to change level
//   TIMEOUT_CYC  - max clk cycles between filtered falling edges in a frame
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   kclk       in   raw PS/2 clock pin (async, idle high)
//   kdata      in   raw PS/2 data pin (async, idle high)
//   byte_out   out  last valid byte, held until the next valid byte
//   byte_valid out  one-cycle pulse when byte_out/keycodeout update
//   keycodeout out  last four valid bytes, newest in [7:0]
//   parity_err out  one-cycle pulse on a frame rejected for bad parity
//   frame_err  out  one-cycle pulse on a bad stop bit or a timeout
// ---------------------------------------------------------------------------
module ps2_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        kclk,
  input  logic        kdata,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [31:0] keycodeout,
  output logic        parity_err,
  output logic        frame_err
);

  localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // A PS/2 frame carries odd parity: data plus parity bit hold an odd
  // number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data,
                                         input logic       par);
    return ^{data, par};
  endfunction

  // -------------------------------------------------------------------------
  // Synchroniser
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] kclk_sync_q;
  logic [SYNC_STAGES-1:0] kdata_sync_q;
  logic                   kclk_s;
  logic                   kdata_s;

  assign kclk_s  = kclk_sync_q[SYNC_STAGES-1];
  assign kdata_s = kdata_sync_q[SYNC_STAGES-1];

  // Shift the raw pins through the synchroniser chains; idle level is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kclk_sync_q  <= {SYNC_STAGES{1'b1}};
      kdata_sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      kclk_sync_q  <= {kclk_sync_q[SYNC_STAGES-2:0], kclk};
      kdata_sync_q <= {kdata_sync_q[SYNC_STAGES-2:0], kdata};
    end
  end

  // -------------------------------------------------------------------------
  // Glitch filter and falling-edge strobe
  // -------------------------------------------------------------------------
  logic              filt_q;
  logic              filt_d;
  logic [FILT_W-1:0] fcnt_q;
  logic [FILT_W-1:0] fcnt_d;
  logic              fall_s;

  // Count disagreeing samples; flip the filtered clock once enough have been
  // seen. The edge strobe fires in the same cycle the 1->0 flip is decided,
  // so the FSM acts on the very edge that updates the filtered clock.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    fall_s = 1'b0;
    if (kclk_s != filt_q) begin
      if (fcnt_q == FILT_MAX) begin
        filt_d = kclk_s;
        fcnt_d = {FILT_W{1'b0}};
        fall_s = filt_q;
      end else begin
        fcnt_d = fcnt_q + FILT_W'(1);
      end
    end else begin
      fcnt_d = {FILT_W{1'b0}};
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b1;
      fcnt_q <= {FILT_W{1'b0}};
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM, timeout and output datapath
  // -------------------------------------------------------------------------
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [2:0]       bitcnt_q;
  logic [2:0]       bitcnt_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             par_q;
  logic             par_d;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;
  logic             tmo_hit_s;

  logic [7:0]       byte_out_q;
  logic [7:0]       byte_out_d;
  logic [31:0]      key_q;
  logic [31:0]      key_d;
  logic             valid_q;
  logic             valid_d;
  logic             perr_q;
  logic             perr_d;
  logic             ferr_q;
  logic             ferr_d;

  assign tmo_hit_s = (tmo_q == TMO_MAX);

  // Timeout counter: cleared by every edge and while idle, saturating
  // otherwise so a stalled frame can never wrap back to a small count.
  always_comb begin
    if (fall_s || (state_q == ST_IDLE)) begin
      tmo_d = {TMO_W{1'b0}};
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Frame sequencing. An edge event always takes priority over a timeout
  // that expires in the same cycle.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    byte_out_d = byte_out_q;
    key_d      = key_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_s && !kdata_s) begin
          state_d  = ST_DATA;
          bitcnt_d = 3'd0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          shift_d  = {kdata_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_DATA;
          end
        end else if (tmo_hit_s) begin
          ferr_d   = 1'b1;
          bitcnt_d = 3'd0;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          par_d   = kdata_s;
          state_d = ST_STOP;
        end else if (tmo_hit_s) begin
          ferr_d   = 1'b1;
          bitcnt_d = 3'd0;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          state_d  = ST_IDLE;
          bitcnt_d = 3'd0;
          // Stop-bit error outranks parity so a frame raises one flag only.
          if (!kdata_s) begin
            ferr_d = 1'b1;
          end else if (!odd_parity_ok(shift_q, par_q)) begin
            perr_d = 1'b1;
          end else begin
            byte_out_d = shift_q;
            key_d      = {key_q[23:0], shift_q};
            valid_d    = 1'b1;
          end
        end else if (tmo_hit_s) begin
          ferr_d   = 1'b1;
          bitcnt_d = 3'd0;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        bitcnt_d = 3'd0;
      end
    endcase
  end

  // FSM, datapath and registered output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      tmo_q      <= {TMO_W{1'b0}};
      byte_out_q <= 8'd0;
      key_q      <= 32'd0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      byte_out_q <= byte_out_d;
      key_q      <= key_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign keycodeout = key_q;
  assign byte_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
`timescale 1ns/1ps
// Directed bench for ps2_frame_rx: a table of whole frames with expected
// results, followed by hand-written glitch, timeout and mid-frame reset cases.
// The bench clock runs at 5 MHz so a 30 us PS/2 half-period is 150 cycles.
module tb_ps2_frame_rx;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 5000;      // 1 ms at 5 MHz
  localparam int HALF        = 150;       // 30 us half-period
  localparam int EDGE_LAT    = SYNC_STAGES + FILTER_LEN;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        kclk = 1'b1;
  logic        kdata = 1'b1;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [31:0] keycodeout;
  logic        parity_err;
  logic        frame_err;

  ps2_frame_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .kclk      (kclk),
    .kdata     (kdata),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .keycodeout(keycodeout),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #100 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int ferr_cyc = -1;
  int last_fall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (byte_valid) n_valid <= n_valid + 1;
    if (parity_err) n_perr <= n_perr + 1;
    if (frame_err) begin
      n_ferr <= n_ferr + 1;
      if (ferr_cyc < 0) ferr_cyc <= cyc;
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic        stop;
    int          exp_valid;
    int          exp_perr;
    int          exp_ferr;
    logic [7:0]  exp_byte;
    logic [31:0] exp_key;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic clear_counts();
    n_valid  = 0;
    n_perr   = 0;
    n_ferr   = 0;
    ferr_cyc = -1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data set up mid-high, clock low for HALF, high for HALF.
  task automatic send_bit(input logic b);
    kdata = b;
    cycles(HALF / 2);
    kclk = 1'b0;
    last_fall = cyc;
    cycles(HALF);
    kclk = 1'b1;
    cycles(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    kdata = 1'b1;
    cycles(40);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " byte_out"},   {24'd0, byte_out},   32'd0);
    check({tag, " keycode"},    keycodeout,          32'd0);
    check({tag, " byte_valid"}, {31'd0, byte_valid}, 32'd0);
    check({tag, " parity_err"}, {31'd0, parity_err}, 32'd0);
    check({tag, " frame_err"},  {31'd0, frame_err},  32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #7;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async reset");
    cycles(5);
    reset_n = 1'b1;
    cycles(5);
  endtask

  initial begin
    //            data   par   stop  v  pe fe byte   keycode
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C, 32'h0000001C};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1, 0, 0, 8'h3C, 32'h00001C3C};
    vecs[2] = '{8'hF0, 1'b1, 1'b1, 1, 0, 0, 8'hF0, 32'h001C3CF0};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 1, 0, 0, 8'h3C, 32'h1C3CF03C};
    vecs[4] = '{8'h15, 1'b0, 1'b1, 1, 0, 0, 8'h15, 32'h3CF03C15};
    vecs[5] = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 8'h15, 32'h3CF03C15}; // bad parity
    vecs[6] = '{8'h2D, 1'b1, 1'b0, 0, 0, 1, 8'h15, 32'h3CF03C15}; // bad stop
    vecs[7] = '{8'h2D, 1'b0, 1'b0, 0, 0, 1, 8'h15, 32'h3CF03C15}; // both bad
    vecs[8] = '{8'h00, 1'b1, 1'b1, 1, 0, 0, 8'h00, 32'hF03C1500};
    vecs[9] = '{8'hFF, 1'b1, 1'b1, 1, 0, 0, 8'hFF, 32'h3C1500FF};

    // Reset state.
    cycles(5);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    cycles(5);

    // Table of whole frames.
    for (int v = 0; v < 10; v++) begin
      clear_counts();
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
      check($sformatf("vec%0d valid_cnt", v), n_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d perr_cnt", v),  n_perr,  vecs[v].exp_perr);
      check($sformatf("vec%0d ferr_cnt", v),  n_ferr,  vecs[v].exp_ferr);
      check($sformatf("vec%0d byte_out", v),  {24'd0, byte_out}, {24'd0, vecs[v].exp_byte});
      check($sformatf("vec%0d keycode", v),   keycodeout, vecs[v].exp_key);
    end

    // Glitches in IDLE: a FILTER_LEN-1 low pulse with kdata low (a start bit
    // if it leaked through), then a single-cycle 200 ns pulse.
    do_reset();
    clear_counts();
    kdata = 1'b0;
    cycles(5);
    kclk = 1'b0;
    cycles(FILTER_LEN - 1);
    kclk = 1'b1;
    cycles(30);
    kdata = 1'b1;
    cycles(50);
    kclk = 1'b0;
    #200;
    kclk = 1'b1;
    cycles(100);
    send_frame(8'h2D, 1'b1, 1'b1);
    check("glitch keycode",   keycodeout, 32'h0000002D);
    check("glitch byte_out",  {24'd0, byte_out}, 32'h0000002D);
    check("glitch valid_cnt", n_valid, 1);
    check("glitch err_cnt",   n_perr + n_ferr, 0);

    // Timeout: five bits, then kclk held high.
    clear_counts();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cycles(TIMEOUT_CYC + 600);
    check("timeout ferr_cnt",  n_ferr, 1);
    check("timeout latency",   ferr_cyc - last_fall, EDGE_LAT + TIMEOUT_CYC);
    check("timeout valid_cnt", n_valid + n_perr, 0);
    check("timeout keycode",   keycodeout, 32'h0000002D);
    clear_counts();
    send_frame(8'h24, 1'b1, 1'b1);
    check("after timeout keycode",   keycodeout, 32'h00002D24);
    check("after timeout valid_cnt", n_valid, 1);
    check("after timeout err_cnt",   n_perr + n_ferr, 0);

    // Reset in the middle of a frame.
    do_reset();
    send_frame(8'h1C, 1'b0, 1'b1);
    check("pre-reset keycode", keycodeout, 32'h0000001C);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    do_reset();
    clear_counts();
    send_frame(8'h1C, 1'b0, 1'b1);
    check("post-reset keycode",   keycodeout, 32'h0000001C);
    check("post-reset valid_cnt", n_valid, 1);
    check("post-reset err_cnt",   n_perr + n_ferr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

Receives PS/2 keyboard frames on the raw `kclk`/`kdata` pins and assembles each validated scan-code byte into a rolling 32-bit keycode history. It sits directly upstream of the keyboard decoder, which turns the keycode history into player choices (U/I/O, Q/W/E) and the game reset (R). It adds three things for the Standoff game: input synchronisation, clock-glitch filtering, and parity, stop-bit and timeout checking. Corrupted or partial frames therefore never reach the decoder.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on `kclk` and `kdata` before any logic (minimum 2).
- `FILTER_LEN`, 8: consecutive identical synchronised `kclk` samples required before the filtered clock changes level.
- `TIMEOUT_CYC`, 50000: maximum `clk` cycles allowed between filtered falling edges inside a frame (1 ms at 50 MHz).

Ports:
- `clk`, input, 1: system clock (50 MHz in the game build). Single clock domain.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `kclk`, input, 1: raw PS/2 clock pin. Asynchronous to `clk`; idle high.
- `kdata`, input, 1: raw PS/2 data pin. Asynchronous to `clk`; idle high.
- `byte_out`, output, 8: last valid received byte. Held until the next valid byte.
- `byte_valid`, output, 1: one-cycle pulse when `byte_out` and `keycodeout` update.
- `keycodeout`, output, 32: last four valid bytes, newest in [7:0].
- `parity_err`, output, 1: one-cycle pulse when a frame is rejected for bad parity.
- `frame_err`, output, 1: one-cycle pulse when a frame is rejected for a bad stop bit or a timeout.

## Operation
- Reset (asynchronous, while `reset_n`=0) puts the block in this state:
  - Synchroniser flops are 1; filtered clock is 1; filter counter is 0.
  - FSM is in IDLE; bit counter is 0; timeout counter is 0.
  - `byte_out`=0, `byte_valid`=0, `keycodeout`=0, `parity_err`=0, `frame_err`=0.
- Synchronisation: `kclk` and `kdata` each pass through `SYNC_STAGES` flops.
- Glitch filter:
  - The filter counter increments while the synchronised `kclk` differs from the filtered clock, and clears when they agree.
  - When the counter reaches `FILTER_LEN`-1, the filtered clock takes the new level and the counter clears.
- Edge event: a one-cycle strobe is raised on each filtered-clock 1→0 transition. The synchronised `kdata` is sampled on that cycle.
- FSM states are IDLE, DATA, PARITY, STOP. Transitions occur only on an edge event, except for timeout.
  - IDLE: sample 0 (start bit) → DATA, bit counter cleared. Sample 1 → stay in IDLE (spurious edge, no error).
  - DATA: shift the sample into the data shift register, LSB first, and increment the bit counter. The 8th bit → PARITY.
  - PARITY: store the sample as the parity bit → STOP.
  - STOP: evaluate the frame and return to IDLE.
    - Stop bit = 0 → pulse `frame_err`. Nothing updates.
    - Stop bit = 1 but the 8 data bits plus the parity bit contain an even number of 1s → pulse `parity_err`. Nothing updates.
    - Otherwise → `byte_out`←data, `keycodeout`←{`keycodeout`[23:0], data}, pulse `byte_valid`.
    - A frame never raises both error flags; a stop-bit error takes precedence over a parity error.
- Timeout:
  - The timeout counter clears on every edge event and while in IDLE; otherwise it increments.
  - At `TIMEOUT_CYC`-1 in any non-IDLE state: pulse `frame_err`, discard the partial frame, go to IDLE.
  - The counter saturates; it does not wrap.
- Edge event and timeout in the same cycle: the edge event wins and the timeout counter clears.
- Break (F0) and extended (E0) prefixes get no special treatment; they are ordinary bytes in the history.

## Timing
- A raw `kclk` fall produces an edge event `SYNC_STAGES`+`FILTER_LEN` cycles later (10 cycles with default parameters).
- `byte_valid`, `byte_out`, `keycodeout` and the error flags change on the clock edge that ends the 11th edge-event cycle (stop bit), i.e. they are registered one cycle after that edge event.
- All outputs are registered; there is no combinational path from the pins.
- Kclk pulses shorter than `FILTER_LEN` cycles are ignored entirely.
- The bench must assume a minimum PS/2 half-period of 30 µs, well above the filter and sync latency.
- There is no back-pressure: the consumer must sample `byte_valid` every cycle, and `keycodeout` is level-valid for the decoder at all times.

## Test plan
- Valid frame for 0x1C (data 0,0,1,1,1,0,0,0 LSB first; parity 0; stop 1) after reset → a single `byte_valid` pulse, `byte_out`=0x1C, `keycodeout`=0x0000001C, no error pulse.
- Frames 0x3C, 0xF0, 0x3C, 0x15 back-to-back → four `byte_valid` pulses, final `keycodeout`=0x3CF03C15.
- Frame 0x1C with parity bit 1 → a single `parity_err` pulse; `keycodeout` and `byte_out` unchanged, no `byte_valid`.
- 200 ns low glitch on `kclk` in IDLE, then a valid 0x2D frame → glitch ignored, `keycodeout`=0x0000002D. Separately, a frame with stop bit 0 → `frame_err` only.
- Five bits of a frame, then `kclk` held high → `frame_err` pulses exactly `TIMEOUT_CYC` cycles after the last edge event, FSM returns to IDLE, and a following 0x24 frame is received correctly.
- `reset_n` low mid-frame after bit 4 with `keycodeout`=0x0000001C → all outputs return to 0 immediately. After release, a full 0x1C frame yields `keycodeout`=0x0000001C.
